// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed 7-segment driver: snapshots a BCD value + overflow flag,
// then scans digits with a blank slot between them. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        ovf_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  an
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        DIG0    = 2'd0,
        DIG1    = 2'd1,
        DIG2    = 2'd2,
        DIG_BAD = 2'd3
    } state_t;

    logic [11:0]      snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [2:0]       an_q, an_d;

    logic             tick;
    logic [3:0]       nib;
    logic             blank_lz;

    // Segment pattern {g,f,e,d,c,b,a}, active-high; non-decimal nibbles show "E".
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    always_comb begin
        snap_d   = snap_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = state_q;
        an_d     = 3'b000;
        seg_d    = 7'h00;
        dp_d     = 1'b0;
        nib      = 4'h0;
        blank_lz = 1'b0;

        tick = (cnt_q == CNT_W'(CLK_DIV - 1));
        if (tick) begin
            cnt_d = '0;
        end

        if (load) begin
            snap_d = bcd_in;
            ovf_d  = ovf_in;
        end

        case (state_q)
            DIG0:    state_d = tick ? DIG1 : DIG0;
            DIG1:    state_d = tick ? DIG2 : DIG1;
            DIG2:    state_d = tick ? DIG0 : DIG2;
            default: state_d = DIG0;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        blank_lz = ((state_q == DIG2) && (snap_q[11:8] == 4'h0)) ||
                   ((state_q == DIG1) && (snap_q[11:4] == 8'h00));
`else
        blank_lz = 1'b0;
`endif

        // Blank slot on tick keeps the previous digit's pattern off the next anode.
        if (!tick) begin
            case (state_q)
                DIG0: begin
                    an_d = 3'b001;
                    nib  = snap_q[3:0];
                end
                DIG1: begin
                    an_d = 3'b010;
                    nib  = snap_q[7:4];
                end
                DIG2: begin
                    an_d = 3'b100;
                    nib  = snap_q[11:8];
                    dp_d = ovf_q;
                end
                default: an_d = 3'b000;
            endcase
            if (an_d != 3'b000 && !blank_lz) begin
                seg_d = seg_decode(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q  <= 12'h000;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= DIG0;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            an_q    <= 3'b000;
        end else begin
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an  = AN_ACTIVE_LOW  ? ~an_q  : an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (CLK_DIV=4, active-high pins).
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_in;
    logic        ovf_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  an;

    bcd_display_scanner #(
        .CLK_DIV       (4),
        .SEG_ACTIVE_LOW(1'b0),
        .AN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bcd_in(bcd_in),
        .ovf_in(ovf_in),
        .load  (load),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   tcyc = 0;
    int   base = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   fin = 1'b0;
    bit   fin_done = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z1 = 7'h00;
    localparam logic [6:0] Z2 = 7'h00;
`else
    localparam logic [6:0] Z1 = 7'h3F;
    localparam logic [6:0] Z2 = 7'h3F;
`endif

    always @(posedge clk) tcyc <= tcyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t < tcyc) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s: expectation for cycle %0d never checked", q[0].nm, q[0].t);
            void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].t == tcyc) begin
            n_tests = n_tests + 1;
            if ({an, seg, dp} !== {q[0].an, q[0].seg, q[0].dp}) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                         q[0].nm, q[0].t, an, seg, dp, q[0].an, q[0].seg, q[0].dp);
            end
            void'(q.pop_front());
        end
        if (fin && !fin_done) begin
            while (q.size() > 0) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL %s: expectation for cycle %0d left unchecked", q[0].nm, q[0].t);
                void'(q.pop_front());
            end
            fin_done = 1'b1;
        end
    end

    task automatic expect_abs(input int t, input logic [2:0] a, input logic [6:0] s,
                              input logic d, input string nm);
        exp_t e;
        e.t = t; e.an = a; e.seg = s; e.dp = d; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic expect_at(input int k, input logic [2:0] a, input logic [6:0] s,
                             input logic d, input string nm);
        expect_abs(base + k, a, s, d, nm);
    endtask

    // Three lit cycles followed by the blank slot.
    task automatic lit_slot(input int k, input logic [2:0] a, input logic [6:0] s,
                            input logic d, input string nm);
        for (int i = 0; i < 3; i++) expect_at(k + i, a, s, d, nm);
        expect_at(k + 3, 3'b000, 7'h00, 1'b0, {nm, "_blank"});
    endtask

    task automatic go_to(input int k);
        while (tcyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 12'h000;
        ovf_in = 1'b0;
        for (int t = 1; t <= 3; t++) expect_abs(t, 3'b000, 7'h00, 1'b0, "reset");
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = tcyc;

        // Load 259 at cycle 0; cycle 1 still shows the old snapshot.
        expect_at(1, 3'b001, 7'h3F, 1'b0, "dig0_pre_load");
        expect_at(4, 3'b000, 7'h00, 1'b0, "first_blank");
        lit_slot(5,  3'b010, 7'h6D, 1'b0, "259_dig1");
        lit_slot(9,  3'b100, 7'h5B, 1'b0, "259_dig2");
        lit_slot(13, 3'b001, 7'h6F, 1'b0, "259_dig0");
        lit_slot(17, 3'b010, 7'h6D, 1'b0, "259_dig1b");
        lit_slot(21, 3'b100, 7'h5B, 1'b0, "259_dig2b");
        load = 1'b1; bcd_in = 12'h259; ovf_in = 1'b0;
        go_to(1);
        load = 1'b0;

        // Overflow on hundreds dp, then cleared by a load with ovf_in=0.
        expect_at(25, 3'b001, 7'h6F, 1'b0, "ovf_dig0_old");
        expect_at(26, 3'b001, 7'h3F, 1'b0, "ovf_dig0_new");
        expect_at(27, 3'b001, 7'h3F, 1'b0, "ovf_dig0_new");
        expect_at(28, 3'b000, 7'h00, 1'b0, "ovf_blank");
        lit_slot(29, 3'b010, Z1,    1'b0, "ovf_dig1");
        lit_slot(33, 3'b100, Z2,    1'b1, "ovf_dig2_dp");
        lit_slot(37, 3'b001, 7'h3F, 1'b0, "ovf_dig0");
        lit_slot(41, 3'b010, Z1,    1'b0, "clr_dig1");
        lit_slot(45, 3'b100, Z2,    1'b0, "clr_dig2_dp");
        go_to(24);
        load = 1'b1; bcd_in = 12'h000; ovf_in = 1'b1;
        go_to(25);
        load = 1'b0;
        go_to(40);
        load = 1'b1; bcd_in = 12'h000; ovf_in = 1'b0;
        go_to(41);
        load = 1'b0;

        // Invalid nibbles decode to E.
        expect_at(49, 3'b001, 7'h3F, 1'b0, "a0f_dig0_old");
        expect_at(50, 3'b001, 7'h79, 1'b0, "a0f_dig0_E");
        expect_at(51, 3'b001, 7'h79, 1'b0, "a0f_dig0_E");
        expect_at(52, 3'b000, 7'h00, 1'b0, "a0f_blank");
        lit_slot(53, 3'b010, 7'h3F, 1'b0, "a0f_dig1");
        lit_slot(57, 3'b100, 7'h79, 1'b0, "a0f_dig2_E");
        lit_slot(61, 3'b001, 7'h79, 1'b0, "a0f_dig0b");
        go_to(48);
        load = 1'b1; bcd_in = 12'hA0F;
        go_to(49);
        load = 1'b0;

        // Load coinciding with tick (cycle 63): next lit slot uses 123.
        lit_slot(65, 3'b010, 7'h5B, 1'b0, "tick_load_dig1");
        lit_slot(69, 3'b100, 7'h06, 1'b0, "tick_load_dig2");
        lit_slot(73, 3'b001, 7'h4F, 1'b0, "tick_load_dig0");
        lit_slot(77, 3'b010, 7'h5B, 1'b0, "tick_load_dig1b");
        expect_at(81, 3'b100, 7'h06, 1'b0, "pre_rst_dig2");
        expect_at(82, 3'b000, 7'h00, 1'b0, "mid_scan_rst");
        go_to(63);
        load = 1'b1; bcd_in = 12'h123;
        go_to(64);
        load = 1'b0;

        // Reset mid DIG2 slot with a competing load; reset must win.
        go_to(81);
        rst = 1'b1; load = 1'b1; bcd_in = 12'h999;
        go_to(82);
        rst = 1'b0; load = 1'b1; bcd_in = 12'h007;
        base = tcyc;
        expect_at(1, 3'b001, 7'h3F, 1'b0, "post_rst_dig0_old");
        expect_at(2, 3'b001, 7'h07, 1'b0, "post_rst_dig0");
        expect_at(3, 3'b001, 7'h07, 1'b0, "post_rst_dig0");
        expect_at(4, 3'b000, 7'h00, 1'b0, "post_rst_blank");
        lit_slot(5,  3'b010, Z1,    1'b0, "007_dig1");
        lit_slot(9,  3'b100, Z2,    1'b0, "007_dig2");
        expect_at(13, 3'b001, 7'h07, 1'b0, "007_dig0b");
        expect_at(14, 3'b001, 7'h07, 1'b0, "007_dig0b");
        expect_at(15, 3'b001, 7'h07, 1'b0, "007_dig0b");
        expect_at(16, 3'b000, 7'h00, 1'b0, "007_blank");
        go_to(1);
        load = 1'b0;

        // Load held high: seg tracks bcd_in two cycles later.
        expect_at(17, 3'b010, 7'h06, 1'b0, "track_1");
        expect_at(18, 3'b010, 7'h5B, 1'b0, "track_2");
        expect_at(19, 3'b010, 7'h4F, 1'b0, "track_3");
        expect_at(20, 3'b000, 7'h00, 1'b0, "track_blank");
        lit_slot(21, 3'b100, Z2,    1'b0, "track_dig2");
        go_to(15);
        load = 1'b1; bcd_in = 12'h010;
        go_to(16);
        bcd_in = 12'h020;
        go_to(17);
        bcd_in = 12'h030;
        go_to(18);
        bcd_in = 12'h040;
        go_to(19);
        load = 1'b0;
        go_to(27);

        fin = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
        if (!fin_done) begin
            $display("FAIL monitor_done: got pending, want done");
            $fatal(1, "monitor did not finish");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
